// File: rtl/retire_trace_pkg.sv
// Shared types and widths for the retire trace buffer.
package retire_trace_pkg;

  localparam int INSTR_W    = 16;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int REG_AW     = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int SEQ_W      = 32;
  localparam int DROP_W     = 16;

  // One retired instruction as seen by the scoreboard.
  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               we;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  wdata;
  } rec_t;

  // Drop counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// Show-ahead synchronous FIFO built from a register array.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The caller never pushes when full without also popping, and never pops when empty.
module sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         wdata_i,
  output T                         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Advance each pointer by one on its own handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO without touching the storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; a push while full-with-pop lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign rdata_o = empty_o ? T'('0) : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retired-instruction records into a FIFO for the scoreboard.
// The CPU is never stalled: a retire arriving while full is dropped, counted and flagged.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      retire_valid,
  input  logic [ADDR_W-1:0]         retire_pc,
  input  logic [INSTR_W-1:0]        retire_instr,
  input  logic                      retire_we,
  input  logic [REG_AW-1:0]         retire_rd,
  input  logic [DATA_W-1:0]         retire_wdata,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output rec_t                      trace_rec,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt,
  input  logic                      clr_stat
);

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic full, empty, push, pop, drop;
  rec_t newRec;

  assign trace_valid = !empty;
  assign pop         = trace_valid && trace_ready;
  assign push        = retire_valid && (!full || pop);
  assign drop        = retire_valid && full && !pop;

  assign newRec = '{seq:   seq_q,
                    pc:    retire_pc,
                    instr: retire_instr,
                    we:    retire_we,
                    rd:    retire_rd,
                    wdata: retire_wdata};

  sync_fifo #(.T(rec_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (newRec),
    .rdata_o (trace_rec),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Sequence numbering counts every retire, so dropped records show up as gaps;
  // a clear and a drop in the same cycle leave the drop visible.
  always_comb begin
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (retire_valid) seq_d = seq_q + 1'b1;
    if (clr_stat) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_d);
    end
  end

  // Sequence counter and drop statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer.
module tb_retire_trace_buffer;
  import retire_trace_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              retireValid;
  logic [15:0]       retirePc;
  logic [15:0]       retireInstr;
  logic              retireWe;
  logic [2:0]        retireRd;
  logic [15:0]       retireWdata;
  logic              traceValid;
  logic              traceReady;
  rec_t              traceRec;
  logic [3:0]        fifoCount;
  logic              overflowFlag;
  logic [15:0]       dropCnt;
  logic              clrStat;

  int total = 0;
  int bad   = 0;

  retire_trace_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .retire_valid (retireValid),
    .retire_pc    (retirePc),
    .retire_instr (retireInstr),
    .retire_we    (retireWe),
    .retire_rd    (retireRd),
    .retire_wdata (retireWdata),
    .trace_valid  (traceValid),
    .trace_ready  (traceReady),
    .trace_rec    (traceRec),
    .fifo_count   (fifoCount),
    .overflow     (overflowFlag),
    .drop_cnt     (dropCnt),
    .clr_stat     (clrStat)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the edge; also checks that the
  // head holds under backpressure and that a full FIFO never grows past DEPTH.
  task automatic step();
    logic holdPrev;
    logic fullNoPop;
    rec_t recPrev;
    holdPrev  = traceValid && !traceReady && !rst;
    fullNoPop = (fifoCount == 4'd8) && retireValid && !(traceValid && traceReady) && !rst;
    recPrev   = traceRec;
    @(posedge clk);
    #1;
    if (holdPrev) begin
      total++;
      if (traceValid !== 1'b1 || traceRec !== recPrev) begin
        bad++;
        $display("[TB] FAIL hold_stable: got valid=%b rec=%h want valid=1 rec=%h",
                 traceValid, traceRec, recPrev);
      end
    end
    if (fullNoPop) begin
      total++;
      if (fifoCount !== 4'd8) begin
        bad++;
        $display("[TB] FAIL full_no_push: got count=%0d want 8", fifoCount);
      end
    end
  endtask

  task automatic setRetire(input logic v, input logic [15:0] pc, input logic [15:0] instr,
                           input logic we, input logic [2:0] rd, input logic [15:0] wdata);
    retireValid = v;
    retirePc    = pc;
    retireInstr = instr;
    retireWe    = we;
    retireRd    = rd;
    retireWdata = wdata;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    traceReady = 1'b0;
    clrStat    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic checkSeq(input string name, input logic [31:0] want);
    total++;
    if (traceValid !== 1'b1 || traceRec.seq !== want) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%b seq=%0d want valid=1 seq=%0d",
               name, traceValid, traceRec.seq, want);
    end
  endtask

  task automatic checkCount(input string name, input logic [3:0] want);
    total++;
    if (fifoCount !== want) begin
      bad++;
      $display("[TB] FAIL %s: got count=%0d want %0d", name, fifoCount, want);
    end
  endtask

  task automatic checkStats(input string name, input logic wantOv, input logic [15:0] wantDrops);
    total++;
    if (overflowFlag !== wantOv || dropCnt !== wantDrops) begin
      bad++;
      $display("[TB] FAIL %s: got overflow=%b drops=%0d want overflow=%b drops=%0d",
               name, overflowFlag, dropCnt, wantOv, wantDrops);
    end
  endtask

  task automatic fillEight();
    traceReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      setRetire(1'b1, 16'(2 * i), 16'h2000, 1'b0, 3'd0, 16'h0);
      step();
    end
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (traceValid !== 1'b0 || traceRec !== rec_t'('0) || fifoCount !== 4'd0 ||
        overflowFlag !== 1'b0 || dropCnt !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got valid=%b rec=%h count=%0d ov=%b drops=%0d want all zero",
               traceValid, traceRec, fifoCount, overflowFlag, dropCnt);
    end
  endtask

  task automatic test_pass_through();
    rec_t want;
    logic [15:0] pcs [3];
    pcs[0] = 16'h0000; pcs[1] = 16'h0002; pcs[2] = 16'h0004;
    traceReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setRetire(1'b1, pcs[i], 16'h1100 + 16'(i), (i != 1), 3'(i + 1), 16'hBEE0 + 16'(i));
      step();
      want = '{seq: 32'(i), pc: pcs[i], instr: 16'h1100 + 16'(i), we: (i != 1),
               rd: 3'(i + 1), wdata: 16'hBEE0 + 16'(i)};
      total++;
      if (traceValid !== 1'b1 || traceRec !== want) begin
        bad++;
        $display("[TB] FAIL pass_rec%0d: got valid=%b rec=%h want valid=1 rec=%h",
                 i, traceValid, traceRec, want);
      end
      checkCount("pass_count", 4'd1);
    end
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    step();
    checkCount("pass_drained", 4'd0);
    total++;
    if (traceValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pass_valid_low: got %b want 0", traceValid);
    end
  endtask

  task automatic test_fill();
    doReset();
    traceReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      setRetire(1'b1, 16'(2 * i), 16'h2000, 1'b0, 3'd0, 16'h0);
      step();
      checkSeq("fill_head", 32'd0);
      checkCount("fill_count", 4'(i + 1));
    end
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkStats("fill_no_overflow", 1'b0, 16'd0);
  endtask

  task automatic test_overflow_drain();
    for (int i = 0; i < 2; i++) begin
      setRetire(1'b1, 16'h0100, 16'h3000, 1'b1, 3'd7, 16'h0);
      step();
    end
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkStats("overflow_stats", 1'b1, 16'd2);
    checkCount("overflow_count", 4'd8);
    traceReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkSeq("drain_seq", 32'(i));
      step();
    end
    checkCount("drain_empty", 4'd0);
    setRetire(1'b1, 16'h0200, 16'h3001, 1'b0, 3'd0, 16'h0);
    step();
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkSeq("after_gap_seq", 32'd10);
    step();
  endtask

  task automatic test_back_to_back();
    doReset();
    fillEight();
    traceReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setRetire(1'b1, 16'h0400, 16'h4000, 1'b0, 3'd0, 16'h0);
      step();
      checkCount("b2b_count", 4'd8);
      checkSeq("b2b_head", 32'(i + 1));
    end
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkStats("b2b_no_drop", 1'b0, 16'd0);
    for (int i = 0; i < 8; i++) step();
    checkCount("b2b_drained", 4'd0);
  endtask

  task automatic test_clr_stat();
    doReset();
    fillEight();
    for (int i = 0; i < 2; i++) begin
      setRetire(1'b1, 16'h0500, 16'h5000, 1'b0, 3'd0, 16'h0);
      step();
    end
    checkStats("pre_clr", 1'b1, 16'd2);
    clrStat = 1'b1;
    step();
    checkStats("clr_with_drop", 1'b1, 16'd1);
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    step();
    clrStat = 1'b0;
    checkStats("clr_alone", 1'b0, 16'd0);
  endtask

  task automatic test_reset_midstream();
    doReset();
    traceReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setRetire(1'b1, 16'h0600 + 16'(2 * i), 16'h6000, 1'b0, 3'd0, 16'h0);
      step();
    end
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkCount("mid_buffered", 4'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (traceValid !== 1'b0 || fifoCount !== 4'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got valid=%b count=%0d want valid=0 count=0",
               traceValid, fifoCount);
    end
    setRetire(1'b1, 16'h0700, 16'h7000, 1'b0, 3'd0, 16'h0);
    step();
    setRetire(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkSeq("mid_first_seq", 32'd0);
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_pass_through();
    test_fill();
    test_overflow_drain();
    test_back_to_back();
    test_clr_stat();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
